// File: rtl/fixed_point_fir_mc.sv
// Time-multiplexed multi-channel FIR: one shared MAC, one tap per cycle, per-channel delay lines,
// shared run-time coefficient RAM, round-half-up and saturate to Q(WIO.WFO) with sticky status.
module fixed_point_fir_mc #(
  parameter int unsigned TAPS = 4,
  parameter int unsigned NCH  = 2,
  parameter int unsigned WI1  = 4,
  parameter int unsigned WF1  = 5,
  parameter int unsigned WIC  = 4,
  parameter int unsigned WFC  = 5,
  parameter int unsigned WIO  = 8,
  parameter int unsigned WFO  = 5,
  localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int unsigned TW  = (TAPS > 1) ? $clog2(TAPS) : 1,
  localparam int unsigned WX  = WI1 + WF1,
  localparam int unsigned WC  = WIC + WFC,
  localparam int unsigned WO  = WIO + WFO
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_channel,
  input  logic [WX-1:0] input_sample,
  input  logic          coeff_wr_en,
  input  logic [TW-1:0] coeff_addr,
  input  logic [WC-1:0] coeff_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_channel,
  output logic [WO-1:0] Filt_Out,
  output logic [1:0]    overFlow,
  input  logic          ovf_clr
);

  localparam int unsigned WP      = WX + WC;
  localparam int unsigned WA      = WP + $clog2(TAPS);
  localparam int unsigned SHIFT   = WF1 + WFC - WFO;
  localparam int unsigned RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam int unsigned WS      = (WA + 1 > WO + 1) ? WA + 1 : WO + 1;

  localparam logic signed [WS-1:0] RND     = (SHIFT > 0) ? (WS'(1) << RND_POS) : '0;
  localparam logic signed [WS-1:0] SAT_MAX = {{(WS-WO+1){1'b0}}, {(WO-1){1'b1}}};
  localparam logic signed [WS-1:0] SAT_MIN = {{(WS-WO+1){1'b1}}, {(WO-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;

  state_t state_q, state_d;

  logic signed [WX-1:0] dline_q [NCH][TAPS];
  logic signed [WC-1:0] coeff_q [TAPS];
  logic signed [WA-1:0] acc_q;
  logic [TW-1:0]        tap_q;
  logic [CW-1:0]        cur_ch_q;

  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] out_ch_q;
  logic [WO-1:0] filt_q;
  logic [1:0]    ovf_q;

  logic                 accept_c, ch_ok_c, addr_ok_c, coeff_wr_ok_c, coeff_rej_c;
  logic                 convert_c, sat_hi_c, sat_lo_c;
  logic signed [WP-1:0] prod_c;
  logic signed [WS-1:0] rnd_c, scaled_c;
  logic [WO-1:0]        filt_c;

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_channel = out_ch_q;
  assign Filt_Out    = filt_q;
  assign overFlow    = ovf_q;

  // Handshake and write qualification
  assign accept_c      = in_valid && in_ready_q;
  assign ch_ok_c       = {1'b0, in_channel} < (CW+1)'(NCH);
  assign addr_ok_c     = {1'b0, coeff_addr} < (TW+1)'(TAPS);
  assign coeff_wr_ok_c = coeff_wr_en && addr_ok_c && (state_q == IDLE) && !accept_c;
  assign coeff_rej_c   = coeff_wr_en && addr_ok_c && !coeff_wr_ok_c;

  // First OUT cycle converts the finished accumulator into the output register
  assign convert_c = (state_q == OUT) && !out_valid_q;

  assign prod_c   = WP'(coeff_q[tap_q]) * WP'(dline_q[cur_ch_q][tap_q]);
  assign rnd_c    = WS'(acc_q) + RND;
  assign scaled_c = rnd_c >>> SHIFT;
  assign sat_hi_c = scaled_c > SAT_MAX;
  assign sat_lo_c = scaled_c < SAT_MIN;
  assign filt_c   = sat_hi_c ? WO'(SAT_MAX) : (sat_lo_c ? WO'(SAT_MIN) : WO'(scaled_c));

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c && ch_ok_c) state_d = MAC;
      MAC:     if (tap_q == TW'(TAPS - 1)) state_d = OUT;
      OUT:     if (out_valid_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_q == OUT) && (state_d == OUT);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Delay lines, MAC and result registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int c = 0; c < int'(NCH); c++)
        for (int t = 0; t < int'(TAPS); t++)
          dline_q[c][t] <= '0;
      acc_q    <= '0;
      tap_q    <= '0;
      cur_ch_q <= '0;
      out_ch_q <= '0;
      filt_q   <= '0;
      ovf_q    <= '0;
    end else begin
      if (accept_c && ch_ok_c) begin
        for (int t = int'(TAPS) - 1; t > 0; t--)
          dline_q[in_channel][t] <= dline_q[in_channel][t-1];
        dline_q[in_channel][0] <= $signed(input_sample);
        cur_ch_q <= in_channel;
      end
      if (accept_c)              acc_q <= '0;
      else if (state_q == MAC)   acc_q <= acc_q + WA'(prod_c);
      if (state_q == MAC) tap_q <= tap_q + TW'(1);
      else                tap_q <= '0;
      if (convert_c) begin
        filt_q   <= filt_c;
        out_ch_q <= cur_ch_q;
      end
      // Sets are ORed after the clear so a same-edge set survives ovf_clr
      ovf_q <= (ovf_clr ? 2'b00 : ovf_q) | {coeff_rej_c, convert_c && (sat_hi_c || sat_lo_c)};
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int t = 0; t < int'(TAPS); t++) coeff_q[t] <= '0;
    end else if (coeff_wr_ok_c) begin
      coeff_q[coeff_addr] <= $signed(coeff_data);
    end
  end

endmodule

// File: tb/tb_fixed_point_fir_mc.sv
// Self-checking bench for fixed_point_fir_mc: directed spec cases plus randomized traffic
// compared against an arithmetic convolution model.
module tb_fixed_point_fir_mc;

  localparam int TAPS = 4;
  localparam int NCH  = 2;
  localparam int SH   = 5;
  localparam int OMAX = 4095;
  localparam int OMIN = -4096;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        in_valid;
  logic        in_ready;
  logic [0:0]  in_channel;
  logic [8:0]  input_sample;
  logic        coeff_wr_en;
  logic [1:0]  coeff_addr;
  logic [8:0]  coeff_data;
  logic        out_valid;
  logic        out_ready;
  logic [0:0]  out_channel;
  logic [12:0] Filt_Out;
  logic [1:0]  overFlow;
  logic        ovf_clr;

  int vectors     = 0;
  int miscompares = 0;

  int         coef_m [TAPS];
  int         dl_m   [NCH][TAPS];
  logic [1:0] ovf_m;

  int imp_smp [5] = '{32, 0, 0, 0, 0};
  int imp_exp [5] = '{16, 8, -32, 64, 0};
  int iso0    [4] = '{16, 8, -32, 64};
  int iso1    [4] = '{16, 24, -8, 56};
  int rnd_smp [4] = '{16, -16, 15, -17};
  int rnd_exp [4] = '{1, 0, 0, -1};

  fixed_point_fir_mc dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_channel   (in_channel),
    .input_sample (input_sample),
    .coeff_wr_en  (coeff_wr_en),
    .coeff_addr   (coeff_addr),
    .coeff_data   (coeff_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_channel  (out_channel),
    .Filt_Out     (Filt_Out),
    .overFlow     (overFlow),
    .ovf_clr      (ovf_clr)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: direct convolution, round half up by floor((acc + half) / 2^SH), clamp
  function automatic longint model_out(input int ch, output bit sat);
    longint acc = 0;
    longint r;
    for (int t = 0; t < TAPS; t++) acc += longint'(coef_m[t]) * longint'(dl_m[ch][t]);
    r = (acc + (longint'(1) << (SH - 1))) >>> SH;
    sat = 1'b0;
    if (r > OMAX) begin r = OMAX; sat = 1'b1; end
    else if (r < OMIN) begin r = OMIN; sat = 1'b1; end
    return r;
  endfunction

  task automatic model_reset();
    for (int t = 0; t < TAPS; t++) begin
      coef_m[t] = 0;
      for (int c = 0; c < NCH; c++) dl_m[c][t] = 0;
    end
    ovf_m = 2'b00;
  endtask

  task automatic write_coeff(input int addr, input int val);
    coeff_wr_en = 1'b1;
    coeff_addr  = 2'(addr);
    coeff_data  = 9'(val);
    tick();
    coeff_wr_en = 1'b0;
    coef_m[addr] = val;
  endtask

  task automatic clear_ovf();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    ovf_m = 2'b00;
    chk("ovf_clear", overFlow, 2'b00);
  endtask

  task automatic start_sample(input int ch, input int smp);
    int n = 0;
    in_valid     = 1'b1;
    in_channel   = 1'(ch);
    input_sample = 9'(smp);
    while (!in_ready && n < 20) begin tick(); n++; end
    chk("in_ready_wait", in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int t = TAPS - 1; t > 0; t--) dl_m[ch][t] = dl_m[ch][t-1];
    dl_m[ch][0] = smp;
  endtask

  task automatic collect(input int ch, input int n0, input int hold, input bit use_exp,
                         input longint exp_v, input string tag);
    int     n = n0;
    bit     sat;
    longint m;
    longint e;
    m = model_out(ch, sat);
    if (sat) ovf_m[0] = 1'b1;
    e = use_exp ? exp_v : m;
    out_ready = (hold == 0);
    while (!out_valid && n < 30) begin tick(); n++; end
    chk({tag, " latency"}, n, TAPS + 1);
    chk({tag, " out_channel"}, out_channel, ch);
    chk({tag, " Filt_Out"}, $signed(Filt_Out), e);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, " hold out_valid"}, out_valid, 1);
      chk({tag, " hold Filt_Out"}, $signed(Filt_Out), e);
      chk({tag, " hold in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    chk({tag, " out_valid drop"}, out_valid, 0);
    chk({tag, " in_ready return"}, in_ready, 1);
  endtask

  task automatic run_sample(input int ch, input int smp, input int hold, input bit use_exp,
                            input longint exp_v, input string tag);
    start_sample(ch, smp);
    collect(ch, 0, hold, use_exp, exp_v, tag);
  endtask

  initial begin
    bit seen;
    RESET = 1'b1; in_valid = 1'b0; in_channel = '0; input_sample = '0;
    coeff_wr_en = 1'b0; coeff_addr = '0; coeff_data = '0; out_ready = 1'b1; ovf_clr = 1'b0;
    model_reset();

    tick(); tick();
    chk("rst in_ready", in_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst Filt_Out", $signed(Filt_Out), 0);
    chk("rst out_channel", out_channel, 0);
    chk("rst overFlow", overFlow, 2'b00);
    RESET = 1'b0;
    tick();
    chk("post-rst in_ready", in_ready, 1);

    // Impulse response
    write_coeff(0, 16); write_coeff(1, 8); write_coeff(2, -32); write_coeff(3, 64);
    for (int i = 0; i < 5; i++) run_sample(0, imp_smp[i], 0, 1'b1, imp_exp[i], "impulse");
    chk("impulse overFlow", overFlow, 2'b00);

    // Channel isolation
    for (int k = 0; k < 4; k++) begin
      run_sample(0, (k == 0) ? 32 : 0, 0, 1'b1, iso0[k], "iso ch0");
      run_sample(1, 32, 0, 1'b1, iso1[k], "iso ch1");
    end

    // Backpressure
    run_sample(0, 32, 10, 1'b0, 0, "backpressure");

    // Coefficient write during MAC, coincident with ovf_clr
    start_sample(0, 0);
    tick();
    coeff_wr_en = 1'b1; coeff_addr = 2'd0; coeff_data = 9'd100; ovf_clr = 1'b1;
    tick();
    coeff_wr_en = 1'b0; ovf_clr = 1'b0;
    ovf_m[1] = 1'b1;
    chk("reject overFlow", overFlow, 2'b10);
    collect(0, 2, 0, 1'b1, 8, "reject");
    clear_ovf();

    // Rounding
    write_coeff(0, 1); write_coeff(1, 0); write_coeff(2, 0); write_coeff(3, 0);
    for (int i = 0; i < 4; i++) run_sample(0, rnd_smp[i], 0, 1'b1, rnd_exp[i], "round");
    chk("round overFlow", overFlow, 2'b00);

    // Saturation
    for (int t = 0; t < TAPS; t++) write_coeff(t, 255);
    for (int i = 0; i < 3; i++) run_sample(1, 255, 0, 1'b0, 0, "sat ramp");
    run_sample(1, 255, 0, 1'b1, 4095, "sat final");
    chk("sat overFlow", overFlow, 2'b01);
    clear_ovf();

    // Randomized traffic against the model
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(3) == 0)
        write_coeff(int'($urandom_range(TAPS - 1)), int'($urandom_range(511)) - 256);
      run_sample(int'($urandom_range(NCH - 1)), int'($urandom_range(511)) - 256,
                 int'($urandom_range(2)), 1'b0, 0, "random");
      chk("random overFlow", overFlow, ovf_m);
      if ($urandom_range(4) == 0) clear_ovf();
    end

    // Reset in the middle of MAC
    start_sample(1, 100);
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    model_reset();
    chk("midrst in_ready", in_ready, 0);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst overFlow", overFlow, 2'b00);
    seen = 1'b0;
    tick();
    chk("midrst in_ready after", in_ready, 1);
    for (int i = 0; i < 10; i++) begin
      seen |= out_valid;
      tick();
    end
    chk("midrst no out_valid", seen, 0);
    run_sample(0, 32, 0, 1'b1, 0, "post-rst impulse ch0");
    run_sample(1, 100, 0, 1'b1, 0, "post-rst impulse ch1");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
